// File: rtl/cpu_phase_seq.sv
// Machine-cycle timing generator for the simple CPU.
// Produces the 2-bit phase code and strobe enable for the downstream 2-to-4
// phase decoder, with run/halt/single-step control, stall hold and a
// retired-instruction counter.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | not executing; waits for start, phase parked at 0
// RUN   | stepping phases 0..3; stall holds the phase, no strobe
// PAUSE | single-step wait between instructions; step releases one
module cpu_phase_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic             step_mode,
    input  logic             step,
    input  logic             stall,
    output logic             I0,
    output logic             I1,
    output logic             En,
    output logic             instr_done,
    output logic             running,
    output logic [CNT_W-1:0] instr_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       phase, phase_nxt;
    logic             halt_pend, halt_pend_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // State, phase, pending-halt flag and retired count registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= 2'd0;
            halt_pend <= 1'b0;
            instr_cnt <= '0;
        end else begin
            state     <= state_nxt;
            phase     <= phase_nxt;
            halt_pend <= halt_pend_nxt;
            instr_cnt <= cnt_nxt;
        end
    end

    // Next-state logic: a halt only takes effect at the instruction boundary
    always_comb begin
        state_nxt     = state;
        phase_nxt     = phase;
        halt_pend_nxt = halt_pend;
        cnt_nxt       = instr_cnt;
        case (state)
            IDLE: begin
                phase_nxt = 2'd0;
                if (start) begin
                    state_nxt     = RUN;
                    halt_pend_nxt = halt_req;
                end
            end
            RUN: begin
                if (halt_req) halt_pend_nxt = 1'b1;
                if (!stall) begin
                    if (phase == 2'd3) begin
                        cnt_nxt   = instr_cnt + CNT_W'(1);
                        phase_nxt = 2'd0;
                        if (halt_pend || halt_req) begin
                            state_nxt     = IDLE;
                            halt_pend_nxt = 1'b0;
                        end else if (step_mode) begin
                            state_nxt = PAUSE;
                        end
                    end else begin
                        phase_nxt = phase + 2'd1;
                    end
                end
            end
            PAUSE: begin
                phase_nxt     = 2'd0;
                halt_pend_nxt = 1'b0;
                // halt has priority over a simultaneous step
                if (halt_req)  state_nxt = IDLE;
                else if (step) state_nxt = RUN;
            end
            default: begin
                state_nxt     = IDLE;
                phase_nxt     = 2'd0;
                halt_pend_nxt = 1'b0;
            end
        endcase
    end

    // Decoder drive: strobe only in non-stalled RUN cycles
    always_comb begin
        running    = (state == RUN);
        En         = running & ~stall;
        instr_done = running & ~stall & (phase == 2'd3);
        I0         = phase[0];
        I1         = phase[1];
    end

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Bench for cpu_phase_seq: directed scenarios followed by random control
// traffic, compared against an instruction-level behavioural model. Two
// instances share the stimulus, one with an 8-bit and one with a 2-bit
// retired counter so counter wrap is exercised continuously.
module tb_cpu_phase_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, halt_req, step_mode, step, stall;
    logic       a_i0, a_i1, a_en, a_done, a_run;
    logic [7:0] a_cnt;
    logic       b_i0, b_i1, b_en, b_done, b_run;
    logic [1:0] b_cnt;

    int checks = 0;
    int errors = 0;

    // behavioural model: instruction-level view
    bit in_instr;       // an instruction is underway
    bit waiting_step;   // single-step pause between instructions
    int done_phases;    // phases already completed in current instruction
    bit stop_after;     // halt requested, stop at end of this instruction
    int retired;        // instructions completed since reset

    always #5 clk = ~clk;

    cpu_phase_seq #(.CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .step_mode(step_mode), .step(step), .stall(stall),
        .I0(a_i0), .I1(a_i1), .En(a_en), .instr_done(a_done),
        .running(a_run), .instr_cnt(a_cnt)
    );

    cpu_phase_seq #(.CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
        .step_mode(step_mode), .step(step), .stall(stall),
        .I0(b_i0), .I1(b_i1), .En(b_en), .instr_done(b_done),
        .running(b_run), .instr_cnt(b_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_instr     = 0;
        waiting_step = 0;
        done_phases  = 0;
        stop_after   = 0;
        retired      = 0;
    endtask

    task automatic model_step();
        if (in_instr) begin
            if (halt_req) stop_after = 1;
            if (!stall) begin
                if (done_phases == 3) begin
                    retired++;
                    done_phases = 0;
                    if (stop_after) begin
                        in_instr   = 0;
                        stop_after = 0;
                    end else if (step_mode) begin
                        in_instr     = 0;
                        waiting_step = 1;
                    end
                end else begin
                    done_phases++;
                end
            end
        end else if (waiting_step) begin
            if (halt_req) waiting_step = 0;
            else if (step) begin
                waiting_step = 0;
                in_instr     = 1;
            end
        end else if (start) begin
            in_instr   = 1;
            stop_after = halt_req;
        end
    endtask

    task automatic check_outputs();
        logic [1:0] code;
        logic       en, done;
        code = in_instr ? 2'(done_phases) : 2'd0;
        en   = in_instr && !stall;
        done = en && (done_phases == 3);
        chk("a_I0", a_i0, code[0]);
        chk("a_I1", a_i1, code[1]);
        chk("a_En", a_en, en);
        chk("a_done", a_done, done);
        chk("a_running", a_run, in_instr);
        chk("a_cnt", a_cnt, retired % 256);
        chk("b_I0", b_i0, code[0]);
        chk("b_I1", b_i1, code[1]);
        chk("b_En", b_en, en);
        chk("b_done", b_done, done);
        chk("b_running", b_run, in_instr);
        chk("b_cnt", b_cnt, retired % 4);
    endtask

    // one clock: check mid-cycle, then let the edge happen and update model;
    // returns 1 time unit after the rising edge, where inputs may change
    task automatic tick();
        @(negedge clk);
        #1 check_outputs();
        @(posedge clk);
        #1 model_step();
    endtask

    // reset asserted mid-cycle: outputs must clear before the next edge
    task automatic async_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_outputs();
        @(posedge clk);
        #1 check_outputs();
        rst = 1'b0;
    endtask

    task automatic run_to_phase(input int p);
        for (int i = 0; i < 16 && !(in_instr && done_phases == p); i++) tick();
        chk("reach_phase", in_instr && done_phases == p, 1'b1);
    endtask

    initial begin
        rst = 1'b1;
        start = 0; halt_req = 0; step_mode = 0; step = 0; stall = 0;
        model_reset();
        #2 check_outputs();
        @(posedge clk);
        #1 rst = 1'b0;

        // free run, 1-cycle start latency, counter reaches 3 after 12 strobes
        start = 1; tick(); start = 0;
        repeat (12) tick();
        chk("cnt_after_12", a_cnt, 8'd3);
        repeat (2) tick();

        // stall holding phase 2 for three cycles
        run_to_phase(2);
        stall = 1; repeat (3) tick(); stall = 0;
        repeat (6) tick();

        // halt at phase 1 still finishes the instruction
        run_to_phase(1);
        halt_req = 1; tick(); halt_req = 0;
        repeat (6) tick();

        // single step: one instruction, long pause, one stepped instruction
        step_mode = 1;
        start = 1; tick(); start = 0;
        repeat (14) tick();
        step = 1; tick(); step = 0;
        repeat (6) tick();

        // halt beats step in PAUSE
        step = 1; halt_req = 1; tick(); step = 0; halt_req = 0;
        repeat (3) tick();
        step_mode = 0;

        // async reset in the middle of an instruction
        start = 1; tick(); start = 0;
        run_to_phase(2);
        async_reset();
        repeat (2) tick();

        // random control traffic
        for (int n = 0; n < 600; n++) begin
            start     = ($urandom_range(0, 5) == 0);
            halt_req  = ($urandom_range(0, 15) == 0);
            step      = ($urandom_range(0, 5) == 0);
            stall     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) step_mode = ~step_mode;
            if ($urandom_range(0, 149) == 0) async_reset();
            else tick();
        end
        start = 0; halt_req = 0; step = 0; stall = 0;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
